pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 3-stage core (F/D, X, M/WB). It decides each cycle whether each pipeline register holds, advances, or takes a bubble. It drives pc_sel, kill_next and the nop-insert controls consumed by the X and X/M pipeline registers. Stall sources are M-stage memory wait, X-stage multi-cycle ops (mul/div start/done handshake), load-use hazards and X-stage control redirects.

Parameters:
LOAD_USE_STALL, 1, 1 = insert one bubble on a load-use hazard; 0 = detection disabled (forwarding handles it)
MEM_TIMEOUT, 255, max MEM_WAIT cycles before abort with mem_err
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
branch_taken_x  in  1  X-stage branch/jump resolved taken
load_x  in  1  X-stage instruction is a load
rd_x  in  5  X-stage destination register
rs1_d, rs2_d  in  5 each  D-stage source registers
rs1_used_d, rs2_used_d  in  1 each  D-stage source actually read
mc_start_x  in  1  X-stage holds a multi-cycle op
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
mem_req_m  in  1  M-stage memory access pending
mem_ready_m  in  1  M-stage memory access complete
stall_f, stall_x, stall_m  out  1 each  hold enable for PC/F-D reg, D-X reg, X-M reg (1 = hold)
bubble_x  out  1  load nop into D-X register
bubble_m  out  1  load nop into X-M register (forces reg_we=0, dmem_rw=0)
pc_sel  out  1  select redirect target
kill_next  out  1  squash instruction returned by sync imem
mc_go  out  1  1-cycle start pulse to the multi-cycle unit
mem_err  out  1  sticky memory-timeout flag
state  out  2  FSM state (debug)
stall_cnt  out  CNT_W  cycles with stall_f=1, saturating

Behaviour:
- States: RUN=0, MEM_WAIT=1, MC_WAIT=2. Code 3 is illegal and goes to RUN next cycle with no outputs asserted.
- Reset (async, rst_n=0): state=RUN. All outputs 0. Internal timeout counter 0. Applies mid-wait: an outstanding mc op is abandoned and mc_go does not re-fire.
- stall_*, bubble_*, pc_sel are combinational from state and inputs. kill_next, mc_go, mem_err, stall_cnt are registered.
- Priority in RUN: memory wait > multi-cycle > redirect > load-use.
- RUN with mem_req_m & !mem_ready_m:
  - stall_f=stall_x=stall_m=1 this cycle.
  - Next state MEM_WAIT; timeout counter=1.
  - pc_sel is suppressed. The branch is re-evaluated when released.
- MEM_WAIT:
  - All stalls 1 while !mem_ready_m; counter increments.
  - mem_ready_m=1: stalls 0 this cycle, next state RUN.
  - Counter==MEM_TIMEOUT: set mem_err, stalls 0, next state RUN. mem_err clears only on reset.
- RUN with mc_start_x (no mem wait):
  - stall_f=stall_x=1, bubble_m=1.
  - Next state MC_WAIT; mc_go=1 in the first MC_WAIT cycle only.
- MC_WAIT:
  - stall_f=stall_x=1, bubble_m=1 until mc_done.
  - Cycle with mc_done: stalls 0, bubble_m 0 (op advances with result), next state RUN.
  - A new mc_start_x seen in RUN afterwards is the next instruction.
  - mc_done arriving in RUN is ignored.
- Redirect (RUN, branch_taken_x, no higher source):
  - pc_sel=1 and bubble_x=1 this cycle.
  - kill_next=1 the following cycle for exactly one cycle.
  - Back-to-back redirects each produce their own kill pulse.
- Load-use (RUN, LOAD_USE_STALL=1, no higher source): the hazard is load_x & rd_x!=0 & ((rs1_used_d & rs1_d==rd_x) | (rs2_used_d & rs2_d==rd_x)).
  - Response: stall_f=1, bubble_x=1 for one cycle; X-M advances. Never triggers on x0.
- stall_cnt: +1 on every cycle with stall_f=1; saturates at all-ones; no wrap.

Decomposition:
- Shared package/header: state encodings (RUN/MEM_WAIT/MC_WAIT), reg-index width 5, NOP encoding used by bubble consumers.
- One natural sub-module: hazard_detect, the combinational load-use comparator. Everything else stays in pipe_hazard_ctrl.

Test Plan:
- Reset released, no requests, 10 cycles -> all stalls/bubbles/pc_sel/kill_next 0, state=0, stall_cnt=0.
- mem_req_m=1, mem_ready_m low 3 cycles then high -> stalls 1 for 3 cycles, 0 on the ready cycle, stall_cnt=3. Repeat with MEM_TIMEOUT=4 and ready never high -> mem_err=1 after 4 cycles, state=0.
- mc_start_x=1, mc_done pulses 5 cycles after mc_go -> mc_go exactly one pulse, stall_x and bubble_m high until the done cycle, then state=0. mc_done in RUN -> no effect.
- load_x=1, rd_x=5, rs2_used_d=1, rs2_d=5 -> stall_f=1, bubble_x=1 one cycle. Same with rd_x=0 -> no stall. With LOAD_USE_STALL=0 -> no stall.
- branch_taken_x=1 one cycle -> pc_sel=1, bubble_x=1 same cycle; kill_next=1 next cycle only. Two consecutive taken -> two kill pulses.
- branch_taken_x with mem wait active -> pc_sel=0 until ready. mc_start_x with mem wait -> MEM_WAIT first, then MC_WAIT. rst_n low in MC_WAIT -> state=0, all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared encodings for the pipeline stall/flush sequencer
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  // Canonical nop (addi x0,x0,0) loaded by the D-X / X-M regs when a bubble is requested
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_MC_WAIT  = 2'd2;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_MEM,
    CAUSE_MC,
    CAUSE_REDIRECT,
    CAUSE_LOAD_USE
  } cause_t;

  typedef struct packed {
    logic stall_f;
    logic stall_x;
    logic stall_m;
    logic bubble_x;
    logic bubble_m;
    logic pc_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic src_match(input logic used, input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - core-side control bundle between pipeline and hazard sequencer
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic               branch_taken_x;
  logic               load_x;
  logic [REG_W-1:0]   rd_x;
  logic [REG_W-1:0]   rs1_d;
  logic [REG_W-1:0]   rs2_d;
  logic               rs1_used_d;
  logic               rs2_used_d;
  logic               mc_start_x;
  logic               mc_done;
  logic               mem_req_m;
  logic               mem_ready_m;

  logic               stall_f;
  logic               stall_x;
  logic               stall_m;
  logic               bubble_x;
  logic               bubble_m;
  logic               pc_sel;
  logic               kill_next;
  logic               mc_go;
  logic               mem_err;
  logic [1:0]         state;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output branch_taken_x, load_x, rd_x, rs1_d, rs2_d, rs1_used_d, rs2_used_d,
    output mc_start_x, mc_done, mem_req_m, mem_ready_m,
    input  stall_f, stall_x, stall_m, bubble_x, bubble_m, pc_sel,
    input  kill_next, mc_go, mem_err, state, stall_cnt
  );

  modport slave (
    input  branch_taken_x, load_x, rd_x, rs1_d, rs2_d, rs1_used_d, rs2_used_d,
    input  mc_start_x, mc_done, mem_req_m, mem_ready_m,
    output stall_f, stall_x, stall_m, bubble_x, bubble_m, pc_sel,
    output kill_next, mc_go, mem_err, state, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - combinational load-use comparator between X and D
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic             i_load_x,
  input  logic [REG_W-1:0] i_rd_x,
  input  logic [REG_W-1:0] i_rs1_d,
  input  logic [REG_W-1:0] i_rs2_d,
  input  logic             i_rs1_used_d,
  input  logic             i_rs2_used_d,
  output logic             o_hazard
);

  logic w_src_hit;

  assign w_src_hit = src_match(i_rs1_used_d, i_rs1_d, i_rd_x) ||
                     src_match(i_rs2_used_d, i_rs2_d, i_rd_x);

  // x0 is hardwired zero, so a load targeting it can never create a dependency
  assign o_hazard = ENABLE && i_load_x && (i_rd_x != '0) && w_src_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 3-stage F/D, X, M/WB core
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int               TO_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(MEM_TIMEOUT);

  logic [1:0]       r_state;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_kill_next;
  logic             r_mc_go;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [1:0]       w_next_state;
  logic             w_mem_block;
  logic             w_load_use;
  logic             w_timeout;
  cause_t           w_cause;
  ctrl_t            w_ctrl;

  pipe_hazard_ctrl_hazard_detect #(
    .ENABLE (LOAD_USE_STALL != 0)
  ) u_hazard_detect (
    .i_load_x     (bus.load_x),
    .i_rd_x       (bus.rd_x),
    .i_rs1_d      (bus.rs1_d),
    .i_rs2_d      (bus.rs2_d),
    .i_rs1_used_d (bus.rs1_used_d),
    .i_rs2_used_d (bus.rs2_used_d),
    .o_hazard     (w_load_use)
  );

  assign w_mem_block = bus.mem_req_m && !bus.mem_ready_m;
  assign w_timeout   = (r_state == ST_MEM_WAIT) && !bus.mem_ready_m && (r_to_cnt == TO_LIMIT);

  always_comb begin
    w_cause = CAUSE_NONE;
    if (r_state == ST_RUN) begin
      if (w_mem_block)             w_cause = CAUSE_MEM;
      else if (bus.mc_start_x)     w_cause = CAUSE_MC;
      else if (bus.branch_taken_x) w_cause = CAUSE_REDIRECT;
      else if (w_load_use)         w_cause = CAUSE_LOAD_USE;
    end
  end

  always_comb begin
    w_ctrl       = CTRL_IDLE;
    w_next_state = r_state;
    case (r_state)
      ST_RUN: begin
        case (w_cause)
          CAUSE_MEM: begin
            w_ctrl.stall_f = 1'b1;
            w_ctrl.stall_x = 1'b1;
            w_ctrl.stall_m = 1'b1;
            w_next_state   = ST_MEM_WAIT;
          end
          CAUSE_MC: begin
            w_ctrl.stall_f  = 1'b1;
            w_ctrl.stall_x  = 1'b1;
            w_ctrl.bubble_m = 1'b1;
            w_next_state    = ST_MC_WAIT;
          end
          CAUSE_REDIRECT: begin
            w_ctrl.pc_sel   = 1'b1;
            w_ctrl.bubble_x = 1'b1;
          end
          CAUSE_LOAD_USE: begin
            w_ctrl.stall_f  = 1'b1;
            w_ctrl.bubble_x = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM_WAIT: begin
        // A timed-out access is released like a completed one; mem_err records it
        if (bus.mem_ready_m || w_timeout) begin
          w_next_state = ST_RUN;
        end else begin
          w_ctrl.stall_f = 1'b1;
          w_ctrl.stall_x = 1'b1;
          w_ctrl.stall_m = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        if (bus.mc_done) begin
          w_next_state = ST_RUN;
        end else begin
          w_ctrl.stall_f  = 1'b1;
          w_ctrl.stall_x  = 1'b1;
          w_ctrl.bubble_m = 1'b1;
        end
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_to_cnt    <= '0;
      r_kill_next <= 1'b0;
      r_mc_go     <= 1'b0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_kill_next <= (w_cause == CAUSE_REDIRECT);
      r_mc_go     <= (w_cause == CAUSE_MC);
      if (w_cause == CAUSE_MEM) begin
        r_to_cnt <= TO_W'(1);
      end else if ((r_state == ST_MEM_WAIT) && w_ctrl.stall_m) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
      if (w_ctrl.stall_f && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Combinational controls are forced low while reset is held so the core sees a clean idle
  assign bus.stall_f   = rst_n && w_ctrl.stall_f;
  assign bus.stall_x   = rst_n && w_ctrl.stall_x;
  assign bus.stall_m   = rst_n && w_ctrl.stall_m;
  assign bus.bubble_x  = rst_n && w_ctrl.bubble_x;
  assign bus.bubble_m  = rst_n && w_ctrl.bubble_m;
  assign bus.pc_sel    = rst_n && w_ctrl.pc_sel;
  assign bus.kill_next = r_kill_next;
  assign bus.mc_go     = r_mc_go;
  assign bus.mem_err   = r_mem_err;
  assign bus.state     = r_state;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector table, corner sequences and random run against a reference model
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       br;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mcs;
    logic       mcd;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  typedef struct packed {
    logic       sf;
    logic       sx;
    logic       sm;
    logic       bx;
    logic       bm;
    logic       pc;
    logic       kill;
    logic       go;
    logic       err;
    logic [1:0] st;
  } obs_t;

  typedef struct {
    stim_t s;
    obs_t  e;
    int    cnt;
  } vec_t;

  typedef struct {
    int     mode;
    int     waited;
    bit     kill;
    bit     go;
    bit     err;
    longint cnt;
  } mdl_t;

  localparam int M_RUN = 0;
  localparam int M_MEM = 1;
  localparam int M_MC  = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  mdl_t m_a;
  mdl_t m_b;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) if_a ();
  pipe_hazard_ctrl_if #(.CNT_W(3))  if_b ();

  pipe_hazard_ctrl #(.LOAD_USE_STALL(1), .MEM_TIMEOUT(4), .CNT_W(32)) u_a (
    .clk (clk), .rst_n (rst_n), .bus (if_a)
  );
  pipe_hazard_ctrl #(.LOAD_USE_STALL(0), .MEM_TIMEOUT(255), .CNT_W(3)) u_b (
    .clk (clk), .rst_n (rst_n), .bus (if_b)
  );

  function automatic stim_t mk_s(bit mreq, bit mrdy, bit mcs, bit mcd, bit br);
    stim_t s = '0;
    s.mreq = mreq; s.mrdy = mrdy; s.mcs = mcs; s.mcd = mcd; s.br = br;
    return s;
  endfunction

  function automatic stim_t mk_l(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, bit u1, bit u2);
    stim_t s = '0;
    s.ld = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
    return s;
  endfunction

  function automatic obs_t mk_e(bit sf, bit sx, bit sm, bit bx, bit bm, bit pc,
                                bit kill, bit go, bit err, logic [1:0] st);
    return {sf, sx, sm, bx, bm, pc, kill, go, err, st};
  endfunction

  function automatic bit lu_hit(stim_t s);
    return s.ld && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
  endfunction

  function automatic obs_t model_eval(mdl_t m, stim_t s, bit lus, int tmo);
    obs_t o = '0;
    case (m.mode)
      M_RUN: begin
        if (s.mreq && !s.mrdy)       begin o.sf = 1; o.sx = 1; o.sm = 1; end
        else if (s.mcs)              begin o.sf = 1; o.sx = 1; o.bm = 1; end
        else if (s.br)               begin o.pc = 1; o.bx = 1; end
        else if (lus && lu_hit(s))   begin o.sf = 1; o.bx = 1; end
      end
      M_MEM: if (!s.mrdy && m.waited < tmo) begin o.sf = 1; o.sx = 1; o.sm = 1; end
      M_MC:  if (!s.mcd) begin o.sf = 1; o.sx = 1; o.bm = 1; end
      default: ;
    endcase
    o.kill = m.kill;
    o.go   = m.go;
    o.err  = m.err;
    o.st   = 2'(m.mode);
    return o;
  endfunction

  task automatic model_next(inout mdl_t m, input stim_t s, input bit lus, input int tmo, input int cntw);
    obs_t   o   = model_eval(m, s, lus, tmo);
    longint cap = (longint'(1) << cntw) - 1;
    if (o.sf && m.cnt < cap) m.cnt++;
    m.kill = 0;
    m.go   = 0;
    case (m.mode)
      M_RUN: begin
        if (s.mreq && !s.mrdy) begin m.mode = M_MEM; m.waited = 1; end
        else if (s.mcs)        begin m.mode = M_MC; m.go = 1; end
        else if (s.br)         m.kill = 1;
      end
      M_MEM: begin
        if (s.mrdy)                 m.mode = M_RUN;
        else if (m.waited >= tmo)   begin m.err = 1; m.mode = M_RUN; end
        else                        m.waited++;
      end
      M_MC: if (s.mcd) m.mode = M_RUN;
      default: m.mode = M_RUN;
    endcase
  endtask

  function automatic mdl_t model_reset();
    mdl_t m;
    m.mode = M_RUN; m.waited = 0; m.kill = 0; m.go = 0; m.err = 0; m.cnt = 0;
    return m;
  endfunction

  task automatic drive(input stim_t s);
    if_a.branch_taken_x = s.br;  if_b.branch_taken_x = s.br;
    if_a.load_x = s.ld;          if_b.load_x = s.ld;
    if_a.rd_x = s.rd;            if_b.rd_x = s.rd;
    if_a.rs1_d = s.rs1;          if_b.rs1_d = s.rs1;
    if_a.rs2_d = s.rs2;          if_b.rs2_d = s.rs2;
    if_a.rs1_used_d = s.u1;      if_b.rs1_used_d = s.u1;
    if_a.rs2_used_d = s.u2;      if_b.rs2_used_d = s.u2;
    if_a.mc_start_x = s.mcs;     if_b.mc_start_x = s.mcs;
    if_a.mc_done = s.mcd;        if_b.mc_done = s.mcd;
    if_a.mem_req_m = s.mreq;     if_b.mem_req_m = s.mreq;
    if_a.mem_ready_m = s.mrdy;   if_b.mem_ready_m = s.mrdy;
  endtask

  function automatic obs_t rd_a();
    return {if_a.stall_f, if_a.stall_x, if_a.stall_m, if_a.bubble_x, if_a.bubble_m, if_a.pc_sel,
            if_a.kill_next, if_a.mc_go, if_a.mem_err, if_a.state};
  endfunction

  function automatic obs_t rd_b();
    return {if_b.stall_f, if_b.stall_x, if_b.stall_m, if_b.bubble_x, if_b.bubble_m, if_b.pc_sel,
            if_b.kill_next, if_b.mc_go, if_b.mem_err, if_b.state};
  endfunction

  task automatic check_obs(input string nm, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b want=%b (sf sx sm bx bm pc kill go err st)", nm, cyc, act, exp);
    end
  endtask

  task automatic check_cnt(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d stall_cnt got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare just after, then advance both models past the posedge
  task automatic step(input stim_t s, input bit use_tbl, input obs_t e_tbl, input int c_tbl);
    @(negedge clk);
    drive(s);
    #1;
    if (use_tbl) begin
      check_obs("tbl_a", rd_a(), e_tbl);
      check_cnt("tbl_cnt_a", longint'(if_a.stall_cnt), longint'(c_tbl));
    end else begin
      check_obs("mdl_a", rd_a(), model_eval(m_a, s, 1'b1, 4));
      check_cnt("mdl_cnt_a", longint'(if_a.stall_cnt), m_a.cnt);
    end
    check_obs("mdl_b", rd_b(), model_eval(m_b, s, 1'b0, 255));
    check_cnt("mdl_cnt_b", longint'(if_b.stall_cnt), m_b.cnt);
    model_next(m_a, s, 1'b1, 4, 32);
    model_next(m_b, s, 1'b0, 255, 3);
    cyc++;
  endtask

  task automatic add(input stim_t s, input obs_t e, input int c);
    vec_t v;
    v.s = s; v.e = e; v.cnt = c;
    tbl.push_back(v);
  endtask

  initial begin
    stim_t idle;
    stim_t junk;
    obs_t  zero;
    idle = '0;
    zero = '0;
    junk = mk_s(1, 0, 1, 1, 1);
    junk.ld = 1; junk.rd = 5'd5; junk.rs1 = 5'd5; junk.u1 = 1;

    add(idle,               mk_e(0,0,0,0,0,0,0,0,0,0), 0);
    add(idle,               mk_e(0,0,0,0,0,0,0,0,0,0), 0);
    add(mk_s(1,0,0,0,0),    mk_e(1,1,1,0,0,0,0,0,0,0), 0);
    add(mk_s(1,0,0,0,0),    mk_e(1,1,1,0,0,0,0,0,0,1), 1);
    add(mk_s(1,0,0,0,0),    mk_e(1,1,1,0,0,0,0,0,0,1), 2);
    add(mk_s(1,1,0,0,0),    mk_e(0,0,0,0,0,0,0,0,0,1), 3);
    add(idle,               mk_e(0,0,0,0,0,0,0,0,0,0), 3);
    add(mk_s(0,0,0,0,1),    mk_e(0,0,0,1,0,1,0,0,0,0), 3);
    add(mk_s(0,0,0,0,1),    mk_e(0,0,0,1,0,1,1,0,0,0), 3);
    add(idle,               mk_e(0,0,0,0,0,0,1,0,0,0), 3);
    add(idle,               mk_e(0,0,0,0,0,0,0,0,0,0), 3);
    add(mk_l(5,0,5,0,1),    mk_e(1,0,0,1,0,0,0,0,0,0), 3);
    add(mk_l(0,0,0,1,1),    mk_e(0,0,0,0,0,0,0,0,0,0), 4);
    add(mk_l(7,7,3,0,1),    mk_e(0,0,0,0,0,0,0,0,0,0), 4);
    add(mk_s(0,0,1,0,0),    mk_e(1,1,0,0,1,0,0,0,0,0), 4);
    add(mk_s(0,0,1,0,0),    mk_e(1,1,0,0,1,0,0,1,0,2), 5);
    for (int i = 0; i < 4; i++)
      add(mk_s(0,0,1,0,0),  mk_e(1,1,0,0,1,0,0,0,0,2), 6 + i);
    add(mk_s(0,0,1,1,0),    mk_e(0,0,0,0,0,0,0,0,0,2), 10);
    add(mk_s(0,0,0,1,0),    mk_e(0,0,0,0,0,0,0,0,0,0), 10);
    add(mk_s(1,0,0,0,1),    mk_e(1,1,1,0,0,0,0,0,0,0), 10);
    for (int i = 0; i < 3; i++)
      add(mk_s(1,0,0,0,1),  mk_e(1,1,1,0,0,0,0,0,0,1), 11 + i);
    add(mk_s(1,0,0,0,1),    mk_e(0,0,0,0,0,0,0,0,0,1), 14);
    add(idle,               mk_e(0,0,0,0,0,0,0,0,1,0), 14);
    add(mk_s(1,0,1,0,0),    mk_e(1,1,1,0,0,0,0,0,1,0), 14);
    add(mk_s(1,1,1,0,0),    mk_e(0,0,0,0,0,0,0,0,1,1), 15);
    add(mk_s(0,0,1,0,0),    mk_e(1,1,0,0,1,0,0,0,1,0), 15);
    add(mk_s(0,0,1,1,0),    mk_e(0,0,0,0,0,0,0,1,1,2), 16);
    add(idle,               mk_e(0,0,0,0,0,0,0,0,1,0), 16);
    add(mk_s(0,0,0,0,1),    mk_e(0,0,0,1,0,1,0,0,1,0), 16);
    add(idle,               mk_e(0,0,0,0,0,0,1,0,1,0), 16);

    // Reset held with every request input active: all outputs must still read 0
    rst_n = 1'b0;
    drive(junk);
    #12;
    check_obs("reset_a", rd_a(), zero);
    check_obs("reset_b", rd_b(), zero);
    check_cnt("reset_cnt_a", longint'(if_a.stall_cnt), 0);
    drive(idle);
    m_a = model_reset();
    m_b = model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) step(idle, 1'b0, zero, 0);
    foreach (tbl[i]) step(tbl[i].s, 1'b1, tbl[i].e, tbl[i].cnt);

    // Asynchronous reset landing in MC_WAIT abandons the op; mc_go must not re-fire
    step(mk_s(0,0,1,0,0), 1'b0, zero, 0);
    step(mk_s(0,0,1,0,1), 1'b0, zero, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_obs("async_rst_a", rd_a(), zero);
    check_obs("async_rst_b", rd_b(), zero);
    check_cnt("async_rst_cnt_a", longint'(if_a.stall_cnt), 0);
    drive(idle);
    m_a = model_reset();
    m_b = model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(idle, 1'b0, zero, 0);

    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      s.mreq = ($urandom % 4) == 0;
      s.mrdy = ($urandom % 3) == 0;
      s.mcs  = ($urandom % 6) == 0;
      s.mcd  = ($urandom % 5) == 0;
      s.br   = ($urandom % 5) == 0;
      s.ld   = $urandom % 2;
      s.rd   = 5'($urandom % 4);
      s.rs1  = 5'($urandom % 4);
      s.rs2  = 5'($urandom % 4);
      s.u1   = $urandom % 2;
      s.u2   = $urandom % 2;
      step(s, 1'b0, zero, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
